// File: rtl/surf_l1_trigger_tx_if.sv
// L1 trigger bus between the SURF trigger logic and the TURF link:
// per-channel level triggers and masks in, L1 pulses and scaler strobes out.
interface surf_l1_trigger_tx_if #(
    parameter int NUM_TRIG = 4
);
    logic [NUM_TRIG-1:0] trig_i;
    logic [NUM_TRIG-1:0] mask_i;
    logic [NUM_TRIG-1:0] L1_o;
    logic [NUM_TRIG-1:0] L1B_o;

    // Trigger source side
    modport master (
        output trig_i,
        output mask_i,
        input  L1_o,
        input  L1B_o
    );

    // L1 transmitter side
    modport slave (
        input  trig_i,
        input  mask_i,
        output L1_o,
        output L1B_o
    );
endinterface

// File: rtl/surf_l1_trigger_tx.sv
// SURF L1 trigger transmitter. Turns per-channel trigger levels into fixed
// width L1 pulses with programmable holdoff, emits a one-cycle active-low
// scaler strobe per raw rising edge, and counts edges lost to busy channels.
// Optional feature macro: L1_TEST_PULSE_EN adds a test_i input whose rising
// edge fires every channel as if all trig_i bits rose together.
module surf_l1_trigger_tx #(
    parameter int NUM_TRIG     = 4,
    parameter int WIDTH_BITS   = 4,
    parameter int HOLDOFF_BITS = 8
) (
    input  logic                    clk250_i,
    input  logic                    rst_n_i,
`ifdef L1_TEST_PULSE_EN
    input  logic                    test_i,
`endif
    surf_l1_trigger_tx_if.slave     l1_bus,
    input  logic [WIDTH_BITS-1:0]   width_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    cnt_clr_i,
    output logic [15:0]             drop_cnt_o
);

    localparam int CNT_BITS = (WIDTH_BITS > HOLDOFF_BITS) ? WIDTH_BITS : HOLDOFF_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t              state_q [NUM_TRIG];
    state_t              state_d [NUM_TRIG];
    logic [CNT_BITS-1:0] cnt_q   [NUM_TRIG];
    logic [CNT_BITS-1:0] cnt_d   [NUM_TRIG];

    logic [NUM_TRIG-1:0] trig_q;
    logic [NUM_TRIG-1:0] trig_qq;
    logic [NUM_TRIG-1:0] trig_edge;
    logic [NUM_TRIG-1:0] edge_q;
    logic [NUM_TRIG-1:0] drop;
    logic [NUM_TRIG-1:0] active;
    logic [16:0]         drop_sum;
    logic                test_edge;

`ifdef L1_TEST_PULSE_EN
    logic test_q;
    logic test_qq;

    // Test pulse synchroniser; reset high so a held level makes no edge
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            test_q  <= 1'b1;
            test_qq <= 1'b1;
        end else begin
            test_q  <= test_i;
            test_qq <= test_q;
        end
    end

    assign test_edge = test_q & ~test_qq;
`else
    assign test_edge = 1'b0;
`endif

    // Trigger input pipeline; reset high so a level held across reset is not an edge
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_q  <= '1;
            trig_qq <= '1;
        end else begin
            trig_q  <= l1_bus.trig_i;
            trig_qq <= trig_q;
        end
    end

    assign trig_edge = (trig_q & ~trig_qq) | {NUM_TRIG{test_edge}};

    // Per-channel next state, counter reload and drop detection
    always_comb begin
        for (int unsigned c = 0; c < NUM_TRIG; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            drop[c]    = 1'b0;
            active[c]  = (state_q[c] == ACTIVE);
            case (state_q[c])
                IDLE: begin
                    if (trig_edge[c] && !l1_bus.mask_i[c]) begin
                        state_d[c] = ACTIVE;
                        cnt_d[c]   = (width_i == '0) ? '0 : CNT_BITS'(width_i) - CNT_BITS'(1);
                    end
                end
                ACTIVE: begin
                    if (cnt_q[c] == '0) begin
                        if (holdoff_i != '0) begin
                            state_d[c] = HOLDOFF;
                            cnt_d[c]   = CNT_BITS'(holdoff_i) - CNT_BITS'(1);
                        end else begin
                            state_d[c] = IDLE;
                        end
                    end else begin
                        cnt_d[c] = cnt_q[c] - CNT_BITS'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt_q[c] == '0) begin
                        state_d[c] = IDLE;
                    end else begin
                        cnt_d[c] = cnt_q[c] - CNT_BITS'(1);
                    end
                end
                default: begin
                    state_d[c] = IDLE;
                    cnt_d[c]   = '0;
                end
            endcase
            // A busy channel is aborted by its mask; otherwise its edges are lost
            if (state_q[c] != IDLE) begin
                if (l1_bus.mask_i[c]) begin
                    state_d[c] = IDLE;
                    cnt_d[c]   = '0;
                end else if (trig_edge[c]) begin
                    drop[c] = 1'b1;
                end
            end
        end
    end

    // Per-channel state and counter registers
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned c = 0; c < NUM_TRIG; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_TRIG; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    // Output registers; mask gates L1 in the same cycle it aborts the FSM
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            edge_q       <= '0;
            l1_bus.L1_o  <= '0;
            l1_bus.L1B_o <= '1;
        end else begin
            edge_q       <= trig_edge;
            l1_bus.L1_o  <= active & ~l1_bus.mask_i;
            l1_bus.L1B_o <= ~edge_q;
        end
    end

    // Sum of this cycle's drops on top of the running count, one bit of headroom
    always_comb begin
        drop_sum = {1'b0, drop_cnt_o};
        for (int unsigned c = 0; c < NUM_TRIG; c++) begin
            drop_sum = drop_sum + 17'(drop[c]);
        end
    end

    // Saturating drop counter with clear taking priority
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            drop_cnt_o <= '0;
        end else if (drop_sum[16]) begin
            drop_cnt_o <= '1;
        end else begin
            drop_cnt_o <= drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_surf_l1_trigger_tx.sv
// Scoreboard bench for surf_l1_trigger_tx: a cycle-indexed interval model
// predicts L1, scaler strobes and drop count; a monitor compares each cycle.
`timescale 1ns/1ps
module tb_surf_l1_trigger_tx;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  width = 4'd1;
    logic [7:0]  holdoff = 8'd0;
    logic        cnt_clr = 1'b0;
    logic [15:0] drop_cnt;
`ifdef L1_TEST_PULSE_EN
    logic        test = 1'b0;
`endif

    surf_l1_trigger_tx_if #(.NUM_TRIG(N)) bus ();

    surf_l1_trigger_tx #(
        .NUM_TRIG(N),
        .WIDTH_BITS(4),
        .HOLDOFF_BITS(8)
    ) dut (
        .clk250_i  (clk),
        .rst_n_i   (rst_n),
`ifdef L1_TEST_PULSE_EN
        .test_i    (test),
`endif
        .l1_bus    (bus),
        .width_i   (width),
        .holdoff_i (holdoff),
        .cnt_clr_i (cnt_clr),
        .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  l1;
        logic [3:0]  l1b;
        logic [15:0] drop;
    } exp_t;
    exp_t sb[$];

    // Model: per channel the cycle span of the pulse and of the busy period
    int   act_from[N];
    int   act_to[N];
    int   busy_to[N];
    bit   pend[N];
    logic [3:0] xprev, xprev2, e_d1;
    int   mdrop;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: compare DUT outputs against the queued prediction for this cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_l1", 16'(bus.L1_o), 16'h0);
            check("rst_l1b", 16'(bus.L1B_o), 16'hF);
            check("rst_drop", drop_cnt, 16'h0);
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                errors++; checks++;
                $display("FAIL sb_stale cyc=%0d actual=none expected_cycle=%0d", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("l1", 16'(bus.L1_o), 16'(e.l1));
                check("l1b", 16'(bus.L1B_o), 16'(e.l1b));
                check("drop", drop_cnt, e.drop);
            end
        end
    end

    task automatic model_init(input logic [3:0] held);
        for (int i = 0; i < N; i++) begin
            act_from[i] = 0; act_to[i] = -1; busy_to[i] = -1; pend[i] = 0;
        end
        xprev = held; xprev2 = 4'hF; e_d1 = 4'h0; mdrop = 0;
    endtask

    // One clock of stimulus plus the model's prediction for the following cycle
    task automatic step(input logic [3:0] t, input logic [3:0] m, input logic [3:0] w,
                        input logic [7:0] h, input logic clr);
        int c, nd, wv;
        logic [3:0] e, l1x;
        bit busy;
        @(posedge clk); #1;
        bus.trig_i = t; bus.mask_i = m; width = w; holdoff = h; cnt_clr = clr;
        c = cyc; nd = 0;
        e = xprev & ~xprev2;
        wv = (w == 0) ? 1 : int'(w);
        for (int i = 0; i < N; i++) begin
            l1x[i] = (c >= act_from[i] && c <= act_to[i]) && !m[i];
            busy = (c <= busy_to[i]);
            if (busy && m[i]) begin
                busy_to[i] = c;
                if (act_to[i] > c) act_to[i] = c;
                pend[i] = 0;
            end else if (pend[i] && c == act_to[i]) begin
                busy_to[i] = c + int'(h);
                pend[i] = 0;
            end
            if (e[i] && !m[i]) begin
                if (busy) nd++;
                else begin
                    act_from[i] = c + 1; act_to[i] = c + wv; busy_to[i] = c + wv; pend[i] = 1;
                end
            end
        end
        if (clr) mdrop = 0;
        else mdrop = (mdrop + nd > 65535) ? 65535 : mdrop + nd;
        sb.push_back('{c + 1, l1x, ~e_d1, 16'(mdrop)});
        e_d1 = e; xprev2 = xprev; xprev = t;
    endtask

    // Hold reset for a few cycles with trig held, release between edges
    task automatic reset_hold(input logic [3:0] held);
        sb.delete();
        bus.trig_i = held;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        model_init(held);
    endtask

    task automatic idle(input int n, input logic [3:0] w, input logic [7:0] h);
        for (int i = 0; i < n; i++) step(4'h0, 4'h0, w, h, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.trig_i = 4'hF; bus.mask_i = 4'h0;
        // Trig held high across reset release: no edges, then normal pulses
        reset_hold(4'hF);
        for (int i = 0; i < 6; i++) step(4'hF, 4'h0, 4'd3, 8'd0, 1'b0);
        idle(2, 4'd3, 8'd0);
        step(4'hF, 4'h0, 4'd3, 8'd0, 1'b0);
        idle(8, 4'd3, 8'd0);

        // Single-cycle trigger, width 3, no holdoff
        step(4'h1, 4'h0, 4'd3, 8'd0, 1'b0);
        idle(8, 4'd3, 8'd0);

        // Second edge during holdoff is dropped but still strobes the scaler
        step(4'h2, 4'h0, 4'd2, 8'd4, 1'b0);
        idle(2, 4'd2, 8'd4);
        step(4'h2, 4'h0, 4'd2, 8'd4, 1'b0);
        idle(12, 4'd2, 8'd4);

        // Masked channel gives no L1 and no drop
        step(4'hF, 4'h4, 4'd2, 8'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(4'h0, 4'h4, 4'd2, 8'd0, 1'b0);

        // Back-to-back pulses one low cycle apart, and width 0
        step(4'h8, 4'h0, 4'd0, 8'd0, 1'b0);
        step(4'h0, 4'h0, 4'd0, 8'd0, 1'b0);
        step(4'h8, 4'h0, 4'd0, 8'd0, 1'b0);
        idle(6, 4'd0, 8'd0);

        // Randomised traffic with occasional masks and clears
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] t, m, w;
            logic [7:0] h;
            t = 4'($urandom);
            m = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            w = 4'($urandom);
            h = 8'($urandom_range(0, 6));
            step(t, m, w, h, $urandom_range(0, 31) == 0);
        end
        idle(30, 4'd1, 8'd0);

        // Reset in the middle of a pulse ends it immediately
        step(4'h1, 4'h0, 4'd8, 8'd0, 1'b0);
        idle(3, 4'd8, 8'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_l1", 16'(bus.L1_o), 16'h0);
        reset_hold(4'h0);
        idle(12, 4'd8, 8'd0);

        // Drive the drop counter to saturation, then clear with a same-cycle drop
        for (int i = 0; i < 40000 && mdrop < 32'hFFF0; i++) begin
            step(4'hF, 4'h0, 4'd15, 8'd255, 1'b0);
            step(4'h0, 4'h0, 4'd15, 8'd255, 1'b0);
        end
        for (int i = 0; i < 2000 && mdrop < 32'hFFFF; i++) begin
            step(4'h1, 4'h0, 4'd15, 8'd255, 1'b0);
            step(4'h0, 4'h0, 4'd15, 8'd255, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(4'hF, 4'h0, 4'd15, 8'd255, 1'b0);
            step(4'h0, 4'h0, 4'd15, 8'd255, 1'b0);
        end
        step(4'hF, 4'h0, 4'd15, 8'd255, 1'b0);
        step(4'h0, 4'h0, 4'd15, 8'd255, 1'b1);
        idle(4, 4'd15, 8'd255);

        @(posedge clk);
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
